reg_file_wide: RTL and testbench

Parametrised successor to the CPU scalar/bitmap register file.
- Scalar bank: NUM_REGS x DATA_W registers. Two combinational read ports, one synchronous write port, same-cycle write-to-read bypass.
- Wide buffer bank: NUM_BUFS x BUF_W registers (note/bitmap frames). Written either in parallel or by a new burst-load engine that fills a buffer DATA_W bits per beat over a valid/ready stream.
- Sits between decode/execute and the frame-streaming logic.

---
 rtl/reg_file_pkg.sv | 23 ++
 rtl/reg_file_wide_buf_load_fsm.sv | 98 +++++++++
 rtl/reg_file_wide.sv | 133 +++++++++++++
 tb/tb_reg_file_wide.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the wide register file: buffer-select width,
// burst-load FSM state encoding and the beat-counter width helper.
package reg_file_pkg;

  // Buffer selects are always two bits wide, even when fewer buffers exist.
  localparam int BA_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } ld_state_e;

  // Ceiling log2 with a floor of one bit, so a single-beat buffer still gets a counter.
  function automatic int beat_cnt_w(input int beats);
    int w;
    w = 1;
    while ((1 << w) < beats) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_wide_buf_load_fsm.sv
// Burst-load engine: accepts DATA_W-bit beats over a valid/ready stream and
// emits one slice write per accepted beat into the captured target buffer.
module buf_load_fsm
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BUF_W    = 1504,
  parameter int NUM_BUFS = 3,
  parameter int CNT_W    = beat_cnt_w(BUF_W / DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_start,
  input  logic [BA_W-1:0]  ld_buf,
  input  logic             ld_abort,
  input  logic             ld_valid,
  input  logic             wbm,
  input  logic [BA_W-1:0]  wbm_addr,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done,
  output logic             beat_we,
  output logic [BA_W-1:0]  beat_buf,
  output logic [CNT_W-1:0] beat_idx
);

  localparam int BEATS = BUF_W / DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [BA_W:0]    BUF_LIMIT = (BA_W + 1)'(NUM_BUFS);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BA_W-1:0]  tgt_q, tgt_d;
  logic             done_q, done_d;
  logic             start_ok;
  logic             stall;
  logic             accept;

  // Handshake and next-state logic; a parallel write to the target buffer wins over a beat.
  always_comb begin
    start_ok = ld_start && ({1'b0, ld_buf} < BUF_LIMIT);
    stall    = wbm && (wbm_addr == tgt_q);
    ld_busy  = (state_q == LOAD);
    ld_ready = ld_busy && !ld_abort && !stall;
    accept   = ld_ready && ld_valid;

    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = LOAD;
          tgt_d   = ld_buf;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign beat_we  = accept;
  assign beat_buf = tgt_q;
  assign beat_idx = cnt_q;
  assign ld_done  = done_q;

  // State, beat counter, captured target and the done pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/reg_file_wide.sv
// Scalar register file with write-to-read bypass plus a bank of wide
// frame buffers, writable in parallel or beat-by-beat through buf_load_fsm.
module reg_file_wide
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int BUF_W    = 1504,
  parameter int NUM_BUFS = 3,
  parameter int ZERO_R0  = 0,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [RA_W-1:0]   rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BA_W-1:0]   rbm_addr,
  output logic [BUF_W-1:0]  rbm_data,
  input  logic              wbm,
  input  logic [BA_W-1:0]   wbm_addr,
  input  logic [BUF_W-1:0]  wbm_data,
  input  logic              ld_start,
  input  logic [BA_W-1:0]   ld_buf,
  input  logic              ld_abort,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int CNT_W = beat_cnt_w(BUF_W / DATA_W);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [BUF_W-1:0]  bufs_q [NUM_BUFS];
  logic [BUF_W-1:0]  bufs_d [NUM_BUFS];

  logic              wr_ok;
  logic              beat_we;
  logic [BA_W-1:0]   beat_buf;
  logic [CNT_W-1:0]  beat_idx;

  buf_load_fsm #(
    .DATA_W  (DATA_W),
    .BUF_W   (BUF_W),
    .NUM_BUFS(NUM_BUFS),
    .CNT_W   (CNT_W)
  ) u_load (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_start(ld_start),
    .ld_buf  (ld_buf),
    .ld_abort(ld_abort),
    .ld_valid(ld_valid),
    .wbm     (wbm),
    .wbm_addr(wbm_addr),
    .ld_ready(ld_ready),
    .ld_busy (ld_busy),
    .ld_done (ld_done),
    .beat_we (beat_we),
    .beat_buf(beat_buf),
    .beat_idx(beat_idx)
  );

  // Scalar write path; register 0 is hardwired to zero when ZERO_R0 is set.
  always_comb begin
    wr_ok  = wr && !((ZERO_R0 != 0) && (wr_addr == '0));
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Combinational scalar reads with same-cycle bypass of the pending write.
  always_comb begin
    if (wr_ok && (wr_addr == rd_addr_1)) begin
      rd_data_1 = wr_data;
    end else if ((ZERO_R0 != 0) && (rd_addr_1 == '0)) begin
      rd_data_1 = '0;
    end else begin
      rd_data_1 = regs_q[rd_addr_1];
    end

    if (wr_ok && (wr_addr == rd_addr_2)) begin
      rd_data_2 = wr_data;
    end else if ((ZERO_R0 != 0) && (rd_addr_2 == '0)) begin
      rd_data_2 = '0;
    end else begin
      rd_data_2 = regs_q[rd_addr_2];
    end
  end

  // Wide buffer updates: whole-buffer parallel write, then any burst slice on top.
  always_comb begin
    bufs_d = bufs_q;
    for (int b = 0; b < NUM_BUFS; b++) begin
      if (wbm && (wbm_addr == BA_W'(b))) begin
        bufs_d[b] = wbm_data;
      end
      if (beat_we && (beat_buf == BA_W'(b))) begin
        bufs_d[b][int'(beat_idx) * DATA_W +: DATA_W] = ld_data;
      end
    end
  end

  // Wide read select; out-of-range selects fall back to buffer 0.
  always_comb begin
    rbm_data = bufs_q[0];
    for (int b = 1; b < NUM_BUFS; b++) begin
      if (rbm_addr == BA_W'(b)) begin
        rbm_data = bufs_q[b];
      end
    end
  end

  // Storage registers for both banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      bufs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
      bufs_q <= bufs_d;
    end
  end

endmodule

// File: tb/tb_reg_file_wide.sv
// Directed bench for reg_file_wide: bypass, zero register, full burst,
// write/beat conflict, abort, illegal selects and async reset mid-burst.
module tb_reg_file_wide;

  localparam int DATA_W = 16;
  localparam int BUF_W  = 1504;
  localparam int BEATS  = BUF_W / DATA_W;

  logic              clk;
  logic              rst_n;
  logic [3:0]        rd_addr_1, rd_addr_2, wr_addr;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        rbm_addr, wbm_addr, ld_buf;
  logic              wbm, ld_start, ld_abort, ld_valid;
  logic [BUF_W-1:0]  wbm_data;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] rd_data_1, rd_data_2;
  logic [BUF_W-1:0]  rbm_data;
  logic              ld_ready, ld_busy, ld_done;

  logic [DATA_W-1:0] z_rd_data_1, z_rd_data_2;
  logic [BUF_W-1:0]  z_rbm_data;
  logic              z_ld_ready, z_ld_busy, z_ld_done;

  logic [BUF_W-1:0]  exp0, exp1, exp2, pat;
  int checks;
  int errors;

  reg_file_wide dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .rbm_addr(rbm_addr), .rbm_data(rbm_data),
    .wbm(wbm), .wbm_addr(wbm_addr), .wbm_data(wbm_data),
    .ld_start(ld_start), .ld_buf(ld_buf), .ld_abort(ld_abort),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
  );

  reg_file_wide #(.ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_1(rd_addr_1), .rd_data_1(z_rd_data_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(z_rd_data_2),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .rbm_addr(rbm_addr), .rbm_data(z_rbm_data),
    .wbm(wbm), .wbm_addr(wbm_addr), .wbm_data(wbm_data),
    .ld_start(ld_start), .ld_buf(ld_buf), .ld_abort(ld_abort),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(z_ld_ready), .ld_busy(z_ld_busy), .ld_done(z_ld_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the given number of clock edges, returning just after the last one.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkWide(input string tag, input logic [BUF_W-1:0] obs, input logic [BUF_W-1:0] expv);
    int first;
    first = 0;
    checks++;
    assert (obs === expv) else begin
      errors++;
      for (int k = BEATS - 1; k >= 0; k--) begin
        if (obs[k*DATA_W +: DATA_W] !== expv[k*DATA_W +: DATA_W]) first = k;
      end
      $error("[TB] FAIL %s slice %0d observed=%h expected=%h", tag, first,
             obs[first*DATA_W +: DATA_W], expv[first*DATA_W +: DATA_W]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rd_addr_1 = 4'd0; rd_addr_2 = 4'd0;
    wr = 1'b0; wr_addr = 4'd0; wr_data = '0;
    rbm_addr = 2'd0; wbm = 1'b0; wbm_addr = 2'd0; wbm_data = '0;
    ld_start = 1'b0; ld_buf = 2'd0; ld_abort = 1'b0; ld_valid = 1'b0; ld_data = '0;

    for (int k = 0; k < BEATS; k++) begin
      exp2[k*DATA_W +: DATA_W] = DATA_W'(k);
      pat[k*DATA_W +: DATA_W]  = DATA_W'(16'h3000 + k);
    end

    // Reset state
    #2;
    checkOutput("reset_rd1", 32'(rd_data_1), 32'h0);
    checkWide("reset_rbm", rbm_data, '0);
    checkOutput("reset_ready", 32'(ld_ready), 32'h0);
    checkOutput("reset_busy", 32'(ld_busy), 32'h0);
    checkOutput("reset_done", 32'(ld_done), 32'h0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);

    // Bypass on reg 5 then registered value
    wr = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_1 = 4'd5;
    #1;
    checkOutput("bypass_rd1", 32'(rd_data_1), 32'hBEEF);
    applyStimulus(1);
    wr = 1'b0;
    #1;
    checkOutput("stored_rd1", 32'(rd_data_1), 32'hBEEF);

    // Reg 0 write: normal instance bypasses, zero-r0 instance reads 0
    wr = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr_2 = 4'd0;
    #1;
    checkOutput("r0_bypass_norm", 32'(rd_data_2), 32'h1234);
    checkOutput("r0_bypass_zero", 32'(z_rd_data_2), 32'h0);
    applyStimulus(1);
    wr = 1'b0;
    #1;
    checkOutput("r0_stored_norm", 32'(rd_data_2), 32'h1234);
    checkOutput("r0_stored_zero", 32'(z_rd_data_2), 32'h0);

    wr = 1'b1; wr_addr = 4'd3; wr_data = 16'h5A5A;
    applyStimulus(1);
    wr = 1'b0; rd_addr_1 = 4'd3; rd_addr_2 = 4'd5;
    #1;
    checkOutput("r3_rd1", 32'(rd_data_1), 32'h5A5A);
    checkOutput("r5_rd2", 32'(rd_data_2), 32'hBEEF);

    // Full burst into buffer 2, valid toggling every other cycle
    ld_start = 1'b1; ld_buf = 2'd2;
    #1;
    checkOutput("burst_idle_busy", 32'(ld_busy), 32'h0);
    applyStimulus(1);
    ld_start = 1'b0;
    #1;
    checkOutput("burst_busy", 32'(ld_busy), 32'h1);
    for (int k = 0; k < BEATS; k++) begin
      ld_valid = 1'b0; ld_data = 16'hDEAD;
      applyStimulus(1);
      ld_valid = 1'b1; ld_data = DATA_W'(k);
      ld_start = (k == 20); ld_buf = 2'd0;
      #1;
      if (k == 0 || k == BEATS - 1) checkOutput("burst_ready", 32'(ld_ready), 32'h1);
      if (k == 50) checkOutput("burst_mid_done", 32'(ld_done), 32'h0);
      applyStimulus(1);
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
    #1;
    checkOutput("burst_done", 32'(ld_done), 32'h1);
    checkOutput("burst_after_busy", 32'(ld_busy), 32'h0);
    checkOutput("burst_after_ready", 32'(ld_ready), 32'h0);
    applyStimulus(1);
    checkOutput("burst_done_pulse", 32'(ld_done), 32'h0);
    rbm_addr = 2'd2;
    #1;
    checkWide("burst_buf2", rbm_data, exp2);

    // Conflict: parallel write to target stalls a beat, write to other buffer does not
    ld_start = 1'b1; ld_buf = 2'd1;
    applyStimulus(1);
    ld_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ld_valid = 1'b1; ld_data = DATA_W'(16'h1000 + k);
      applyStimulus(1);
    end
    ld_data = 16'h00AA; wbm = 1'b1; wbm_addr = 2'd1; wbm_data = '1;
    #1;
    checkOutput("conflict_stall", 32'(ld_ready), 32'h0);
    applyStimulus(1);
    wbm_addr = 2'd0; wbm_data = pat;
    #1;
    checkOutput("conflict_other_ok", 32'(ld_ready), 32'h1);
    applyStimulus(1);
    wbm = 1'b0; ld_abort = 1'b1; ld_data = 16'h1234;
    #1;
    checkOutput("abort_ready", 32'(ld_ready), 32'h0);
    applyStimulus(1);
    ld_abort = 1'b0; ld_valid = 1'b0;
    #1;
    checkOutput("conflict_abort_busy", 32'(ld_busy), 32'h0);
    checkOutput("conflict_abort_done", 32'(ld_done), 32'h0);
    exp1 = '1;
    exp1[10*DATA_W +: DATA_W] = 16'h00AA;
    rbm_addr = 2'd1;
    #1;
    checkWide("conflict_buf1", rbm_data, exp1);
    rbm_addr = 2'd0;
    #1;
    checkWide("conflict_buf0", rbm_data, pat);

    // Abort after five beats into buffer 0
    exp0 = pat;
    ld_start = 1'b1; ld_buf = 2'd0;
    applyStimulus(1);
    ld_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1; ld_data = DATA_W'(16'hC000 + k);
      exp0[k*DATA_W +: DATA_W] = DATA_W'(16'hC000 + k);
      applyStimulus(1);
    end
    ld_valid = 1'b0; ld_abort = 1'b1;
    applyStimulus(1);
    ld_abort = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(ld_busy), 32'h0);
    checkOutput("abort_done", 32'(ld_done), 32'h0);
    applyStimulus(1);
    checkOutput("abort_done_late", 32'(ld_done), 32'h0);
    checkWide("abort_buf0", rbm_data, exp0);
    rbm_addr = 2'd2;
    #1;
    checkWide("abort_buf2_kept", rbm_data, exp2);

    // Out-of-range selects
    ld_start = 1'b1; ld_buf = 2'd3;
    applyStimulus(1);
    ld_start = 1'b0;
    #1;
    checkOutput("illegal_start_busy", 32'(ld_busy), 32'h0);
    rbm_addr = 2'd3;
    #1;
    checkWide("illegal_read_buf0", rbm_data, exp0);
    wbm = 1'b1; wbm_addr = 2'd3; wbm_data = '1;
    applyStimulus(1);
    wbm = 1'b0; rbm_addr = 2'd0;
    #1;
    checkWide("illegal_wbm_buf0", rbm_data, exp0);
    rbm_addr = 2'd1;
    #1;
    checkWide("illegal_wbm_buf1", rbm_data, exp1);

    // Async reset in the middle of a burst
    ld_start = 1'b1; ld_buf = 2'd2;
    applyStimulus(1);
    ld_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ld_valid = 1'b1; ld_data = DATA_W'(16'h4000 + k);
      applyStimulus(1);
    end
    ld_data = 16'h4028; rd_addr_1 = 4'd3; rbm_addr = 2'd2;
    #1;
    checkOutput("pre_reset_busy", 32'(ld_busy), 32'h1);
    checkOutput("pre_reset_rd1", 32'(rd_data_1), 32'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rd1", 32'(rd_data_1), 32'h0);
    checkOutput("async_rd2", 32'(rd_data_2), 32'h0);
    checkWide("async_rbm", rbm_data, '0);
    checkOutput("async_busy", 32'(ld_busy), 32'h0);
    checkOutput("async_ready", 32'(ld_ready), 32'h0);
    ld_valid = 1'b0;
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("post_reset_busy", 32'(ld_busy), 32'h0);
    checkOutput("post_reset_done", 32'(ld_done), 32'h0);
    for (int b = 0; b < 3; b++) begin
      rbm_addr = 2'(b);
      #1;
      checkWide("post_reset_buf", rbm_data, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
